// File: rtl/eigen2x2_fx.sv
`default_nettype none
// ============================================================================
// Module      : eigen2x2_fx
// Description : Iterative fixed-point eigenvalue engine for a 2x2 matrix
//               [[a1,a2],[a3,a4]]. Computes trace/difference/cross product,
//               forms the discriminant, takes a bit-serial non-restoring
//               integer square root and produces saturated eigenvalues (or
//               real/imaginary parts for a complex-conjugate pair).
// Revision    : 1.0 - initial release
// ============================================================================
module eigen2x2_fx #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] a2,
  input  logic [WIDTH-1:0] a3,
  input  logic [WIDTH-1:0] a4,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] v1,
  output logic [WIDTH-1:0] v2,
  output logic             complex,
  output logic             ovf
);

  localparam int MW = 2*WIDTH + 2;  // discriminant magnitude
  localparam int DW = 2*WIDTH + 4;  // signed discriminant
  localparam int RW = WIDTH + 5;    // signed sqrt partial remainder
  localparam int XW = WIDTH + 3;    // pre-saturation result
  localparam int CW = $clog2(WIDTH + 1);

  if (WIDTH < 8 || WIDTH > 32 || FRAC < 0 || FRAC >= WIDTH) begin : g_param_check
    $error("eigen2x2_fx: WIDTH must be 8..32 and FRAC in 0..WIDTH-1");
  end

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CALC = 3'd1,
    S_DISC = 3'd2,
    S_SQRT = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t state_q, state_d;

  logic signed [WIDTH-1:0]   a1_q, a2_q, a3_q, a4_q;
  logic signed [WIDTH:0]     sum_q, diff_q;
  logic signed [2*WIDTH-1:0] prod_q;
  logic                      cplx_q;
  logic [MW-1:0]             mag_q;
  logic [RW-1:0]             rem_q;
  logic [WIDTH:0]            root_q;
  logic [CW-1:0]             cnt_q;
  logic                      busy_q, done_q, complex_q, ovf_q;
  logic [WIDTH-1:0]          v1_q, v2_q;

  logic signed [DW-1:0] w_diff_x, w_prod_x, w_disc;
  logic [MW-1:0]        w_mag;
  logic [1:0]           w_pair;
  logic [RW-1:0]        w_rem_sh, w_root4, w_rem_n;
  logic signed [XW-1:0] w_sum_x, w_root_x, w_r1, w_r2, w_h1, w_h2;
  logic [WIDTH-1:0]     w_s1, w_s2;
  logic                 w_o1, w_o2;

  // Clamp a pre-saturation result to WIDTH bits; MSB of the return flags a clamp.
  function automatic logic [WIDTH:0] sat_fn(input logic [XW-1:0] v);
    if ((&v[XW-1:WIDTH-1]) || !(|v[XW-1:WIDTH-1]))
      return {1'b0, v[WIDTH-1:0]};
    else
      return {1'b1, v[XW-1], {(WIDTH-1){~v[XW-1]}}};
  endfunction

  // Discriminant, one sqrt step and the final eigenvalue arithmetic.
  always_comb begin
    w_diff_x = DW'(diff_q);
    w_prod_x = DW'(prod_q);
    w_disc   = (w_diff_x * w_diff_x) + (w_prod_x <<< 2);
    w_mag    = MW'(w_disc[DW-1] ? -w_disc : w_disc);

    // Non-restoring step: bring down the next radicand pair, then add or
    // subtract the trial term depending on the sign of the running remainder.
    w_pair   = mag_q[MW-1 -: 2];
    w_rem_sh = (rem_q << 2) | RW'(w_pair);
    w_root4  = RW'(root_q) << 2;
    w_rem_n  = rem_q[RW-1] ? (w_rem_sh + (w_root4 | RW'(3)))
                           : (w_rem_sh - (w_root4 | RW'(1)));

    w_sum_x  = XW'(sum_q);
    w_root_x = $signed({2'b00, root_q});
    w_r1     = cplx_q ? w_sum_x  : (w_sum_x + w_root_x);
    w_r2     = cplx_q ? w_root_x : (w_sum_x - w_root_x);
    w_h1     = w_r1 >>> 1;
    w_h2     = w_r2 >>> 1;
    {w_o1, w_s1} = sat_fn(w_h1);
    {w_o2, w_s2} = sat_fn(w_h2);
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state sequencing through the pipeline phases.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_CALC;
      S_CALC:  state_d = S_DISC;
      S_DISC:  state_d = S_SQRT;
      S_SQRT:  if (cnt_q == '0) state_d = S_FIN;
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath registers, handshake flags and held results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a1_q <= '0; a2_q <= '0; a3_q <= '0; a4_q <= '0;
      sum_q <= '0; diff_q <= '0; prod_q <= '0;
      cplx_q <= 1'b0; mag_q <= '0; rem_q <= '0; root_q <= '0; cnt_q <= '0;
      busy_q <= 1'b0; done_q <= 1'b0; complex_q <= 1'b0; ovf_q <= 1'b0;
      v1_q <= '0; v2_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a1_q <= a1; a2_q <= a2; a3_q <= a3; a4_q <= a4;
            busy_q <= 1'b1;
          end
        end
        S_CALC: begin
          sum_q  <= a1_q + a4_q;
          diff_q <= a1_q - a4_q;
          prod_q <= a2_q * a3_q;
        end
        S_DISC: begin
          cplx_q <= w_disc[DW-1];
          mag_q  <= w_mag;
          rem_q  <= '0;
          root_q <= '0;
          cnt_q  <= CW'(WIDTH);
        end
        S_SQRT: begin
          rem_q  <= w_rem_n;
          root_q <= (root_q << 1) | {{WIDTH{1'b0}}, ~w_rem_n[RW-1]};
          mag_q  <= mag_q << 2;
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
        end
        S_FIN: begin
          v1_q      <= w_s1;
          v2_q      <= w_s2;
          complex_q <= cplx_q;
          ovf_q     <= w_o1 | w_o2;
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign v1      = v1_q;
  assign v2      = v2_q;
  assign complex = complex_q;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_eigen2x2_fx.sv
`default_nettype none
// ============================================================================
// Module      : tb_eigen2x2_fx
// Description : Self-checking bench for eigen2x2_fx at WIDTH=16/FRAC=8 and
//               WIDTH=32/FRAC=16, using a plain-arithmetic eigenvalue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_eigen2x2_fx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        s16, s32;
  logic [15:0] p1, p2, p3, p4;
  logic [31:0] q1, q2, q3, q4;
  logic        b16, d16, c16, o16, b32, d32, c32, o32;
  logic [15:0] x16, y16;
  logic [31:0] x32, y32;

  int pass_cnt  = 0;
  int total_cnt = 0;

  eigen2x2_fx #(.WIDTH(16), .FRAC(8)) dut16 (
    .clk(clk), .rst(rst), .start(s16),
    .a1(p1), .a2(p2), .a3(p3), .a4(p4),
    .busy(b16), .done(d16), .v1(x16), .v2(y16), .complex(c16), .ovf(o16)
  );

  eigen2x2_fx #(.WIDTH(32), .FRAC(16)) dut32 (
    .clk(clk), .rst(rst), .start(s32),
    .a1(q1), .a2(q2), .a3(q3), .a4(q4),
    .busy(b32), .done(d32), .v1(x32), .v2(y32), .complex(c32), .ovf(o32)
  );

  // Sign-extend the low w bits of v.
  function automatic longint sx(input logic [31:0] v, input int w);
    return longint'($signed(v << (32 - w))) >>> (32 - w);
  endfunction

  // Reference: eigenvalues of [[m1,m2],[m3,m4]] from the closed-form formula.
  function automatic void model(input int w, input logic [31:0] m1, m2, m3, m4,
                                output logic [31:0] e1, e2, output logic ec, eo);
    logic signed [79:0] s1, s2, s3, s4, sum, diff, disc, mag, root, cand, r1, r2, hi, lo;
    s1 = sx(m1, w); s2 = sx(m2, w); s3 = sx(m3, w); s4 = sx(m4, w);
    sum  = s1 + s4;
    diff = s1 - s4;
    disc = diff * diff + 4 * s2 * s3;
    ec   = (disc < 0);
    mag  = ec ? -disc : disc;
    root = 0;
    for (int b = w; b >= 0; b--) begin
      cand = root + (80'sd1 <<< b);
      if (cand * cand <= mag) root = cand;
    end
    if (ec) begin r1 = sum; r2 = root; end
    else    begin r1 = sum + root; r2 = sum - root; end
    r1 = r1 >>> 1;
    r2 = r2 >>> 1;
    hi = (80'sd1 <<< (w - 1)) - 1;
    lo = -(80'sd1 <<< (w - 1));
    eo = 1'b0;
    if (r1 > hi) begin r1 = hi; eo = 1'b1; end
    if (r1 < lo) begin r1 = lo; eo = 1'b1; end
    if (r2 > hi) begin r2 = hi; eo = 1'b1; end
    if (r2 < lo) begin r2 = lo; eo = 1'b1; end
    e1 = r1[31:0];
    e2 = r2[31:0];
  endfunction

  // Start one 16-bit operation; lat = cycles from accepting edge to done (-1 on timeout).
  task automatic run16(input logic [15:0] m1, m2, m3, m4, output int lat);
    p1 = m1; p2 = m2; p3 = m3; p4 = m4;
    s16 = 1'b1;
    @(posedge clk); #1;
    s16 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      if (d16) begin lat = c; break; end
    end
  endtask

  task automatic run32(input logic [31:0] m1, m2, m3, m4, output int lat);
    q1 = m1; q2 = m2; q3 = m3; q4 = m4;
    s32 = 1'b1;
    @(posedge clk); #1;
    s32 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 80; c++) begin
      @(posedge clk); #1;
      if (d32) begin lat = c; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; s16 = 1'b0; s32 = 1'b0;
    p1 = '0; p2 = '0; p3 = '0; p4 = '0;
    q1 = '0; q2 = '0; q3 = '0; q4 = '0;
    repeat (3) @(posedge clk);
    #1;
    total_cnt++; if (b16 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", b16); else pass_cnt++;
    total_cnt++; if (d16 !== 1'b0) $display("FAIL reset_done: got %b expected 0", d16); else pass_cnt++;
    total_cnt++; if (x16 !== 16'h0) $display("FAIL reset_v1: got %h expected 0000", x16); else pass_cnt++;
    total_cnt++; if (y16 !== 16'h0) $display("FAIL reset_v2: got %h expected 0000", y16); else pass_cnt++;
    total_cnt++; if (c16 !== 1'b0) $display("FAIL reset_complex: got %b expected 0", c16); else pass_cnt++;
    total_cnt++; if (o16 !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", o16); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_directed();
    int lat;
    run16(16'h0300, 16'h0100, 16'h0200, 16'h0400, lat);
    total_cnt++; if (lat !== 20) $display("FAIL case1_latency: got %0d expected 20", lat); else pass_cnt++;
    total_cnt++; if (b16 !== 1'b0) $display("FAIL case1_busy_in_done: got %b expected 0", b16); else pass_cnt++;
    total_cnt++; if (x16 !== 16'h0500) $display("FAIL case1_v1: got %h expected 0500", x16); else pass_cnt++;
    total_cnt++; if (y16 !== 16'h0200) $display("FAIL case1_v2: got %h expected 0200", y16); else pass_cnt++;
    total_cnt++; if ({c16, o16} !== 2'b00) $display("FAIL case1_flags: got %b%b expected 00", c16, o16); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (d16 !== 1'b0) $display("FAIL case1_done_pulse: got %b expected 0", d16); else pass_cnt++;
    total_cnt++; if (x16 !== 16'h0500) $display("FAIL case1_hold_v1: got %h expected 0500", x16); else pass_cnt++;

    run16(16'h0000, 16'hFF00, 16'h0100, 16'h0000, lat);
    total_cnt++; if (lat !== 20) $display("FAIL rot_latency: got %0d expected 20", lat); else pass_cnt++;
    total_cnt++; if (c16 !== 1'b1) $display("FAIL rot_complex: got %b expected 1", c16); else pass_cnt++;
    total_cnt++; if (x16 !== 16'h0000) $display("FAIL rot_v1: got %h expected 0000", x16); else pass_cnt++;
    total_cnt++; if (y16 !== 16'h0100) $display("FAIL rot_v2: got %h expected 0100", y16); else pass_cnt++;
    total_cnt++; if (o16 !== 1'b0) $display("FAIL rot_ovf: got %b expected 0", o16); else pass_cnt++;

    run16(16'h0100, 16'h0100, 16'h0100, 16'h0000, lat);
    total_cnt++; if (x16 !== 16'h019E) $display("FAIL disc5_v1: got %h expected 019e", x16); else pass_cnt++;
    total_cnt++; if (y16 !== 16'hFF62) $display("FAIL disc5_v2: got %h expected ff62", y16); else pass_cnt++;
    total_cnt++; if ({c16, o16} !== 2'b00) $display("FAIL disc5_flags: got %b%b expected 00", c16, o16); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int lat;
    run16(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00, lat);
    total_cnt++; if (x16 !== 16'h7FFF) $display("FAIL sat_v1: got %h expected 7fff", x16); else pass_cnt++;
    total_cnt++; if (y16 !== 16'h0000) $display("FAIL sat_v2: got %h expected 0000", y16); else pass_cnt++;
    total_cnt++; if (o16 !== 1'b1) $display("FAIL sat_ovf: got %b expected 1", o16); else pass_cnt++;
    // Still inside the done cycle: the next start is presented right now.
    run16(16'h0200, 16'h0000, 16'h0000, 16'h0200, lat);
    total_cnt++; if (lat !== 20) $display("FAIL b2b_latency: got %0d expected 20", lat); else pass_cnt++;
    total_cnt++; if (x16 !== 16'h0200) $display("FAIL b2b_v1: got %h expected 0200", x16); else pass_cnt++;
    total_cnt++; if (y16 !== 16'h0200) $display("FAIL b2b_v2: got %h expected 0200", y16); else pass_cnt++;
    total_cnt++; if ({c16, o16} !== 2'b00) $display("FAIL b2b_flags: got %b%b expected 00", c16, o16); else pass_cnt++;
  endtask

  task automatic test_ignore_busy();
    int ndone, first;
    logic [15:0] r1, r2;
    ndone = 0; first = -1; r1 = '0; r2 = '0;
    @(posedge clk); #1;
    p1 = 16'h0300; p2 = 16'h0100; p3 = 16'h0200; p4 = 16'h0400;
    s16 = 1'b1;
    @(posedge clk); #1;
    s16 = 1'b0;
    total_cnt++; if (b16 !== 1'b1) $display("FAIL ign_busy_after_accept: got %b expected 1", b16); else pass_cnt++;
    for (int c = 1; c <= 45; c++) begin
      if (c == 3) begin
        s16 = 1'b1;
        p1 = 16'h0000; p2 = 16'hFF00; p3 = 16'h0100; p4 = 16'h0000;
      end else begin
        s16 = 1'b0;
      end
      if (c == 8) begin p1 = 16'h1234; p4 = 16'hF000; end
      @(posedge clk); #1;
      if (d16) begin
        ndone++;
        if (first < 0) begin first = c; r1 = x16; r2 = y16; end
      end
    end
    total_cnt++; if (ndone !== 1) $display("FAIL ign_done_count: got %0d expected 1", ndone); else pass_cnt++;
    total_cnt++; if (first !== 20) $display("FAIL ign_latency: got %0d expected 20", first); else pass_cnt++;
    total_cnt++; if (r1 !== 16'h0500) $display("FAIL ign_v1: got %h expected 0500", r1); else pass_cnt++;
    total_cnt++; if (r2 !== 16'h0200) $display("FAIL ign_v2: got %h expected 0200", r2); else pass_cnt++;
  endtask

  task automatic test_reset_abort();
    int lat, ndone;
    ndone = 0;
    p1 = 16'h0100; p2 = 16'h0100; p3 = 16'h0100; p4 = 16'h0000;
    s16 = 1'b1;
    @(posedge clk); #1;
    s16 = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    total_cnt++; if (x16 !== 16'h0) $display("FAIL abort_v1: got %h expected 0000", x16); else pass_cnt++;
    total_cnt++; if (y16 !== 16'h0) $display("FAIL abort_v2: got %h expected 0000", y16); else pass_cnt++;
    total_cnt++; if ({b16, d16, c16, o16} !== 4'b0000) $display("FAIL abort_flags: got %b%b%b%b expected 0000", b16, d16, c16, o16); else pass_cnt++;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (d16) ndone++;
    end
    total_cnt++; if (ndone !== 0) $display("FAIL abort_no_done: got %0d expected 0", ndone); else pass_cnt++;
    run16(16'h0100, 16'h0100, 16'h0100, 16'h0000, lat);
    total_cnt++; if (lat !== 20) $display("FAIL abort_restart_latency: got %0d expected 20", lat); else pass_cnt++;
    total_cnt++; if (x16 !== 16'h019E) $display("FAIL abort_restart_v1: got %h expected 019e", x16); else pass_cnt++;
  endtask

  task automatic test_random16();
    int lat;
    logic [15:0] m[4];
    logic [31:0] r, e1, e2;
    logic ec, eo;
    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 4; k++) begin
        r = $urandom;
        m[k] = (i % 2 == 1) ? {{4{r[11]}}, r[11:0]} : r[15:0];
      end
      model(16, {16'h0, m[0]}, {16'h0, m[1]}, {16'h0, m[2]}, {16'h0, m[3]}, e1, e2, ec, eo);
      run16(m[0], m[1], m[2], m[3], lat);
      total_cnt++; if (lat !== 20) $display("FAIL rnd16_latency[%0d]: got %0d expected 20", i, lat); else pass_cnt++;
      total_cnt++; if (x16 !== e1[15:0]) $display("FAIL rnd16_v1[%0d]: got %h expected %h", i, x16, e1[15:0]); else pass_cnt++;
      total_cnt++; if (y16 !== e2[15:0]) $display("FAIL rnd16_v2[%0d]: got %h expected %h", i, y16, e2[15:0]); else pass_cnt++;
      total_cnt++; if ({c16, o16} !== {ec, eo}) $display("FAIL rnd16_flags[%0d]: got %b%b expected %b%b", i, c16, o16, ec, eo); else pass_cnt++;
    end
  endtask

  task automatic test_wide();
    int lat;
    logic [31:0] m[4];
    logic [31:0] e1, e2;
    logic ec, eo;
    run32(32'h00030000, 32'h00010000, 32'h00020000, 32'h00040000, lat);
    total_cnt++; if (lat !== 36) $display("FAIL w32_latency: got %0d expected 36", lat); else pass_cnt++;
    total_cnt++; if (x32 !== 32'h00050000) $display("FAIL w32_v1: got %h expected 00050000", x32); else pass_cnt++;
    total_cnt++; if (y32 !== 32'h00020000) $display("FAIL w32_v2: got %h expected 00020000", y32); else pass_cnt++;
    total_cnt++; if ({c32, o32} !== 2'b00) $display("FAIL w32_flags: got %b%b expected 00", c32, o32); else pass_cnt++;
    for (int i = 0; i < 12; i++) begin
      for (int k = 0; k < 4; k++) m[k] = $urandom;
      if (i % 2 == 1) for (int k = 0; k < 4; k++) m[k] = 32'(sx(m[k], 24));
      model(32, m[0], m[1], m[2], m[3], e1, e2, ec, eo);
      run32(m[0], m[1], m[2], m[3], lat);
      total_cnt++; if (lat !== 36) $display("FAIL rnd32_latency[%0d]: got %0d expected 36", i, lat); else pass_cnt++;
      total_cnt++; if (x32 !== e1) $display("FAIL rnd32_v1[%0d]: got %h expected %h", i, x32, e1); else pass_cnt++;
      total_cnt++; if (y32 !== e2) $display("FAIL rnd32_v2[%0d]: got %h expected %h", i, y32, e2); else pass_cnt++;
      total_cnt++; if ({c32, o32} !== {ec, eo}) $display("FAIL rnd32_flags[%0d]: got %b%b expected %b%b", i, c32, o32, ec, eo); else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_ignore_busy();
    test_reset_abort();
    test_random16();
    test_wide();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
